acorn_init_engine: RTL and testbench

- Parametrised ACORN-128 initialization engine and the successor to the single-step init loop.
- Captures the key and IV on a start handshake and zeroes the 293-bit state.
- Runs INIT_STEPS state-update steps, processing STEPS_PER_CYCLE steps each clock with ca=cb=1 and an internally generated message-bit schedule.
- Presents the final state to the encryption datapath with a done/valid handshake.

---
 rtl/acorn_pkg.sv | 59 +++++
 rtl/acorn_step.sv | 46 ++++
 rtl/acorn_init_engine.sv | 160 ++++++++++++++++
 tb/tb_acorn_init_engine.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acorn_pkg.sv
// ---------------------------------------------------------------------------
// acorn_pkg
// Shared constants, types and helper functions for the ACORN-128
// initialization engine.
//   ACORN_STATE_W    : width of the ACORN-128 state register (293 bits)
//   ACORN_INIT_STEPS : number of state-update steps in the standard init
//   ACORN_KEY_W      : key / IV width for ACORN-128
//   fsm_state_t      : engine control states (IDLE, RUN, DONE)
//   LFSR_* / KS_* / FB_* : bit positions used by StateUpdate128
// ---------------------------------------------------------------------------
package acorn_pkg;

    localparam int ACORN_STATE_W    = 293;
    localparam int ACORN_INIT_STEPS = 1792;
    localparam int ACORN_KEY_W      = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // The state is six concatenated LFSRs plus a 4-bit tail. Each segment
    // head is refreshed from two taps before the filter is evaluated. The
    // update order matters: later segments see earlier segments' new values
    // only where the reference algorithm does, so the arrays are walked
    // from index 0 upward.
    localparam int LFSR_SEGMENTS = 6;
    localparam int LFSR_DST   [LFSR_SEGMENTS] = '{289, 230, 193, 154, 107, 61};
    localparam int LFSR_TAP_A [LFSR_SEGMENTS] = '{235, 196, 160, 111,  66, 23};
    localparam int LFSR_TAP_B [LFSR_SEGMENTS] = '{230, 193, 154, 107,  61,  0};

    // Keystream filter taps.
    localparam int KS_LIN_A = 12;
    localparam int KS_LIN_B = 154;
    localparam int KS_MAJ_A = 235;
    localparam int KS_MAJ_B = 61;
    localparam int KS_MAJ_C = 193;
    localparam int KS_CH_X  = 230;
    localparam int KS_CH_Y  = 111;
    localparam int KS_CH_Z  = 66;

    // Nonlinear feedback taps.
    localparam int FB_LIN   = 0;
    localparam int FB_INV   = 107;
    localparam int FB_MAJ_A = 244;
    localparam int FB_MAJ_B = 23;
    localparam int FB_MAJ_C = 160;
    localparam int FB_CA    = 196;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch3(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

endpackage

// File: rtl/acorn_step.sv
// ---------------------------------------------------------------------------
// acorn_step
// One combinational ACORN-128 StateUpdate128 step.
// Ports:
//   state_in   : current 293-bit state
//   mbit       : message bit injected into the feedback this step
//   ca, cb     : ACORN control bits
//   state_next : state after the step
//   ks         : keystream bit produced by this step
// ---------------------------------------------------------------------------
module acorn_step
    import acorn_pkg::*;
(
    input  logic [ACORN_STATE_W-1:0] state_in,
    input  logic                     mbit,
    input  logic                     ca,
    input  logic                     cb,
    output logic [ACORN_STATE_W-1:0] state_next,
    output logic                     ks
);

    logic [ACORN_STATE_W-1:0] lin;
    logic                     fb;

    // Refresh the LFSR segment heads in place, then derive the keystream
    // and feedback from the refreshed state, then shift by one with the
    // new bit entering at the top.
    always_comb begin
        lin = state_in;
        for (int i = 0; i < LFSR_SEGMENTS; i++) begin
            lin[LFSR_DST[i]] = lin[LFSR_DST[i]] ^ lin[LFSR_TAP_A[i]] ^ lin[LFSR_TAP_B[i]];
        end

        ks = lin[KS_LIN_A] ^ lin[KS_LIN_B]
           ^ maj3(lin[KS_MAJ_A], lin[KS_MAJ_B], lin[KS_MAJ_C])
           ^ ch3(lin[KS_CH_X], lin[KS_CH_Y], lin[KS_CH_Z]);

        fb = lin[FB_LIN] ^ ~lin[FB_INV]
           ^ maj3(lin[FB_MAJ_A], lin[FB_MAJ_B], lin[FB_MAJ_C])
           ^ (ca & lin[FB_CA])
           ^ (cb & ks);

        state_next = {fb ^ mbit, lin[ACORN_STATE_W-1:1]};
    end

endmodule

// File: rtl/acorn_init_engine.sv
// ---------------------------------------------------------------------------
// acorn_init_engine
// ACORN-128 initialization engine. Captures key/IV on start, zeroes the
// state and runs INIT_STEPS update steps, STEPS_PER_CYCLE per clock, with
// ca=cb=1 and the standard init message schedule.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin initialization (honoured only while ready=1)
//   key_in      : key, bit 0 consumed first
//   iv_in       : IV, bit 0 consumed first
//   ready       : engine idle or finished, start will be accepted
//   busy        : engine running
//   done        : one-cycle pulse on completion
//   state_valid : high while the finished state is presented
//   state_out   : state register
//   step_count  : steps completed since the last accepted start
//   mbit_dbg    : message bits applied this cycle (bit j = step base+j)
// ---------------------------------------------------------------------------
module acorn_init_engine
    import acorn_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1,
    parameter int INIT_STEPS      = ACORN_INIT_STEPS,
    parameter int KEY_W           = ACORN_KEY_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [KEY_W-1:0]           key_in,
    input  logic [KEY_W-1:0]           iv_in,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic                       state_valid,
    output logic [ACORN_STATE_W-1:0]   state_out,
    output logic [11:0]                step_count,
    output logic [STEPS_PER_CYCLE-1:0] mbit_dbg
);

    // Reject configurations the datapath cannot support.
    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 &&
        STEPS_PER_CYCLE != 4 && STEPS_PER_CYCLE != 8) begin : g_bad_steps
        $error("acorn_init_engine: STEPS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    if ((INIT_STEPS % STEPS_PER_CYCLE) != 0 || INIT_STEPS < 257 ||
        INIT_STEPS > 4095) begin : g_bad_init
        $error("acorn_init_engine: INIT_STEPS must be a multiple of STEPS_PER_CYCLE in 257..4095");
    end
    if (KEY_W != ACORN_KEY_W) begin : g_bad_key
        $error("acorn_init_engine: KEY_W must be 128");
    end

    localparam logic [11:0] STEP_INC  = 12'(STEPS_PER_CYCLE);
    localparam logic [11:0] LAST_BASE = 12'(INIT_STEPS - STEPS_PER_CYCLE);

    fsm_state_t                                    fsm;
    logic [KEY_W-1:0]                              key_reg;
    logic [KEY_W-1:0]                              iv_reg;
    logic [ACORN_STATE_W-1:0]                      state_reg;
    logic [STEPS_PER_CYCLE-1:0]                    mbits;
    logic [STEPS_PER_CYCLE:0][ACORN_STATE_W-1:0]   chain;
    logic [STEPS_PER_CYCLE-1:0]                    unused_ks;

    // Message schedule: key, then IV, then the key with bit 0 flipped once
    // as the domain-separation bit, then the key repeated. lo is the mod-128
    // index, kept in 7 bits so it wraps without an explicit modulo.
    function automatic logic msg_bit(input logic [KEY_W-1:0] k,
                                     input logic [KEY_W-1:0] v,
                                     input logic [11:0]      idx,
                                     input logic [6:0]       lo);
        logic b;
        if (idx < 12'd128) begin
            b = k[lo];
        end else if (idx < 12'd256) begin
            b = v[lo];
        end else if (idx == 12'd256) begin
            b = ~k[0];
        end else begin
            b = k[lo];
        end
        return b;
    endfunction

    // Message bits for the steps handled this cycle.
    always_comb begin
        mbits = '0;
        for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
            mbits[j] = msg_bit(key_reg, iv_reg,
                               step_count + 12'(j),
                               step_count[6:0] + 7'(j));
        end
    end

    // Unrolled update chain; purely combinational between state registers.
    assign chain[0] = state_reg;

    for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_step
        acorn_step u_step (
            .state_in   (chain[j]),
            .mbit       (mbits[j]),
            .ca         (1'b1),
            .cb         (1'b1),
            .state_next (chain[j+1]),
            .ks         (unused_ks[j])
        );
    end

    // Control FSM with registered status outputs. A start in IDLE or DONE
    // captures key/IV and restarts from a zero state; starts during RUN are
    // ignored. done is a single-cycle pulse on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm         <= IDLE;
            key_reg     <= '0;
            iv_reg      <= '0;
            state_reg   <= '0;
            step_count  <= '0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            state_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE, DONE: begin
                    if (start) begin
                        fsm         <= RUN;
                        key_reg     <= key_in;
                        iv_reg      <= iv_in;
                        state_reg   <= '0;
                        step_count  <= '0;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                        state_valid <= 1'b0;
                    end
                end
                RUN: begin
                    state_reg  <= chain[STEPS_PER_CYCLE];
                    step_count <= step_count + STEP_INC;
                    if (step_count == LAST_BASE) begin
                        fsm         <= DONE;
                        ready       <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_valid <= 1'b1;
                    end
                end
                default: begin
                    fsm   <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_out = state_reg;
    assign mbit_dbg  = (fsm == RUN) ? mbits : '0;

endmodule

// File: tb/tb_acorn_init_engine.sv
// ---------------------------------------------------------------------------
// tb_acorn_init_engine
// Drives a one-step-per-cycle and an eight-step-per-cycle engine, compares
// final states against a bit-serial reference of the ACORN-128 init, and
// checks the message schedule, handshake timing and corner sequences.
// ---------------------------------------------------------------------------
module tb_acorn_init_engine;

    localparam logic [127:0] KEY_A = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] IV_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'hdeadbeefcafef00d_0badc0de12345678;
    localparam logic [127:0] IV_B  = 128'h5a5a5a5a0f0f0f0f_a5a5a5a5f0f0f0f1;

    logic         clk;
    logic         rst_1, rst_8, start_1, start_8;
    logic [127:0] key_in, iv_in;

    logic         ready_1, busy_1, done_1, valid_1;
    logic [292:0] state_1;
    logic [11:0]  step_1;
    logic [0:0]   mbit_1;

    logic         ready_8, busy_8, done_8, valid_8;
    logic [292:0] state_8;
    logic [11:0]  step_8;
    logic [7:0]   mbit_8;

    logic         use8;
    logic         cur_ready, cur_busy, cur_done, cur_valid;
    logic [292:0] cur_state;
    logic [11:0]  cur_step;
    logic [7:0]   cur_mbit;

    int total = 0;
    int bad   = 0;

    logic [292:0] g_zero, g_a, g_b;

    typedef struct {
        logic         use8;
        logic [127:0] key;
        logic [127:0] iv;
        int           step;
        logic [7:0]   exp;
    } mbit_vec_t;

    mbit_vec_t vecs[23];

    acorn_init_engine #(.STEPS_PER_CYCLE(1)) dut_1 (
        .clk(clk), .rst(rst_1), .start(start_1), .key_in(key_in), .iv_in(iv_in),
        .ready(ready_1), .busy(busy_1), .done(done_1), .state_valid(valid_1),
        .state_out(state_1), .step_count(step_1), .mbit_dbg(mbit_1)
    );

    acorn_init_engine #(.STEPS_PER_CYCLE(8)) dut_8 (
        .clk(clk), .rst(rst_8), .start(start_8), .key_in(key_in), .iv_in(iv_in),
        .ready(ready_8), .busy(busy_8), .done(done_8), .state_valid(valid_8),
        .state_out(state_8), .step_count(step_8), .mbit_dbg(mbit_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe whichever engine the current test targets.
    assign cur_ready = use8 ? ready_8 : ready_1;
    assign cur_busy  = use8 ? busy_8  : busy_1;
    assign cur_done  = use8 ? done_8  : done_1;
    assign cur_valid = use8 ? valid_8 : valid_1;
    assign cur_state = use8 ? state_8 : state_1;
    assign cur_step  = use8 ? step_8  : step_1;
    assign cur_mbit  = use8 ? mbit_8  : {7'd0, mbit_1};

    // Bit-serial reference of the ACORN-128 initialization.
    function automatic logic [292:0] acorn_golden(input logic [127:0] k, input logic [127:0] v);
        bit st [293];
        bit m, ks, f;
        logic [292:0] r;
        for (int i = 0; i < 293; i++) st[i] = 1'b0;
        for (int i = 0; i < 1792; i++) begin
            if (i < 128)       m = k[i];
            else if (i < 256)  m = v[i - 128];
            else if (i == 256) m = k[0] ^ 1'b1;
            else               m = k[i % 128];
            st[289] = st[289] ^ st[235] ^ st[230];
            st[230] = st[230] ^ st[196] ^ st[193];
            st[193] = st[193] ^ st[160] ^ st[154];
            st[154] = st[154] ^ st[111] ^ st[107];
            st[107] = st[107] ^ st[66]  ^ st[61];
            st[61]  = st[61]  ^ st[23]  ^ st[0];
            ks = st[12] ^ st[154]
               ^ ((st[235] & st[61]) ^ (st[235] & st[193]) ^ (st[61] & st[193]))
               ^ ((st[230] & st[111]) ^ ((st[230] ^ 1'b1) & st[66]));
            f = st[0] ^ (st[107] ^ 1'b1)
              ^ ((st[244] & st[23]) ^ (st[244] & st[160]) ^ (st[23] & st[160]))
              ^ st[196] ^ ks;
            for (int j = 0; j < 292; j++) st[j] = st[j + 1];
            st[292] = f ^ m;
        end
        for (int i = 0; i < 293; i++) r[i] = st[i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [292:0] actual, input logic [292:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Present key/IV with start for one cycle; returns at the negedge
    // after the accept edge. Inputs are then scrambled so any re-sampling
    // during RUN would corrupt the result.
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] v);
        key_in = k;
        iv_in  = v;
        if (use8) start_8 = 1'b1; else start_1 = 1'b1;
        @(negedge clk);
        start_1 = 1'b0;
        start_8 = 1'b0;
        key_in  = ~k;
        iv_in   = ~v;
    endtask

    task automatic reset_dut();
        if (use8) rst_8 = 1'b1; else rst_1 = 1'b1;
        @(negedge clk);
        rst_1 = 1'b0;
        rst_8 = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checkOutput({name, "_ready"}, cur_ready, 1);
        checkOutput({name, "_busy"},  cur_busy,  0);
        checkOutput({name, "_done"},  cur_done,  0);
        checkOutput({name, "_valid"}, cur_valid, 0);
        checkOutput({name, "_state"}, cur_state, 0);
        checkOutput({name, "_step"},  cur_step,  0);
        checkOutput({name, "_mbit"},  cur_mbit,  0);
    endtask

    // Count negedges (1 = first negedge after the accept edge) until done.
    task automatic wait_done(output int cycles, output bit seen);
        cycles = 1;
        seen   = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if (cur_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait_step(input int target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if (int'(cur_step) == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_and_check(input string name, input logic [127:0] k, input logic [127:0] v,
                                 input logic [292:0] golden, input int latency);
        int cycles;
        bit seen;
        applyStimulus(k, v);
        checkOutput({name, "_busy_run"}, cur_busy, 1);
        wait_done(cycles, seen);
        checkOutput({name, "_done_seen"}, seen, 1);
        checkOutput({name, "_latency"}, cycles, latency);
        checkOutput({name, "_state"}, cur_state, golden);
        checkOutput({name, "_step"}, cur_step, 1792);
        checkOutput({name, "_ready"}, cur_ready, 1);
        checkOutput({name, "_valid"}, cur_valid, 1);
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, cur_done, 0);
        checkOutput({name, "_valid_hold"}, cur_valid, 1);
        checkOutput({name, "_state_hold"}, cur_state, golden);
    endtask

    initial begin
        forever begin
            #10_000_000;
            $display("[TB] FAIL watchdog: simulation time limit reached");
            $fatal(1, "[TB] watchdog expired");
        end
    end

    initial begin
        int  cycles;
        bit  seen, ok, done_during;
        bit  new_run;

        rst_1 = 1'b1;
        rst_8 = 1'b1;
        start_1 = 1'b0;
        start_8 = 1'b0;
        key_in = '0;
        iv_in  = '0;
        use8   = 1'b0;

        // Message-schedule vectors, expected bits worked out by hand.
        vecs[0]  = '{1'b0, 128'h1, 128'h0, 0,    8'h01};
        vecs[1]  = '{1'b0, 128'h1, 128'h0, 1,    8'h00};
        vecs[2]  = '{1'b0, 128'h1, 128'h0, 127,  8'h00};
        vecs[3]  = '{1'b0, 128'h1, 128'h0, 128,  8'h00};
        vecs[4]  = '{1'b0, 128'h1, 128'h0, 255,  8'h00};
        vecs[5]  = '{1'b0, 128'h1, 128'h0, 256,  8'h00};
        vecs[6]  = '{1'b0, 128'h1, 128'h0, 257,  8'h00};
        vecs[7]  = '{1'b0, 128'h1, 128'h0, 384,  8'h01};
        vecs[8]  = '{1'b0, 128'h80000000000000000000000000000001, 128'h40000000000000000000000000000002, 127,  8'h01};
        vecs[9]  = '{1'b0, 128'h80000000000000000000000000000001, 128'h40000000000000000000000000000002, 129,  8'h01};
        vecs[10] = '{1'b0, 128'h80000000000000000000000000000001, 128'h40000000000000000000000000000002, 254,  8'h01};
        vecs[11] = '{1'b0, 128'h80000000000000000000000000000001, 128'h40000000000000000000000000000002, 256,  8'h00};
        vecs[12] = '{1'b0, 128'h80000000000000000000000000000001, 128'h40000000000000000000000000000002, 383,  8'h01};
        vecs[13] = '{1'b0, 128'h80000000000000000000000000000001, 128'h40000000000000000000000000000002, 385,  8'h00};
        vecs[14] = '{1'b0, 128'h80000000000000000000000000000001, 128'h40000000000000000000000000000002, 1791, 8'h01};
        vecs[15] = '{1'b1, 128'h1, 128'h0, 0,    8'h01};
        vecs[16] = '{1'b1, 128'h1, 128'h0, 256,  8'h00};
        vecs[17] = '{1'b1, 128'h1, 128'h0, 384,  8'h01};
        vecs[18] = '{1'b1, 128'hc30000000000000000000000000000a5, 128'h3c, 0,    8'ha5};
        vecs[19] = '{1'b1, 128'hc30000000000000000000000000000a5, 128'h3c, 8,    8'h00};
        vecs[20] = '{1'b1, 128'hc30000000000000000000000000000a5, 128'h3c, 128,  8'h3c};
        vecs[21] = '{1'b1, 128'hc30000000000000000000000000000a5, 128'h3c, 256,  8'ha4};
        vecs[22] = '{1'b1, 128'hc30000000000000000000000000000a5, 128'h3c, 1784, 8'hc3};

        g_zero = acorn_golden('0, '0);
        g_a    = acorn_golden(KEY_A, IV_A);
        g_b    = acorn_golden(KEY_B, IV_B);

        repeat (2) @(negedge clk);
        rst_1 = 1'b0;
        rst_8 = 1'b0;
        @(negedge clk);
        use8 = 1'b0;
        check_idle("reset_s1");
        use8 = 1'b1;
        check_idle("reset_s8");

        // Full runs with zero and non-trivial key/IV on both engines.
        use8 = 1'b0;
        run_and_check("s1_zero", '0, '0, g_zero, 1793);
        use8 = 1'b1;
        run_and_check("s8_zero", '0, '0, g_zero, 225);
        use8 = 1'b0;
        run_and_check("s1_keya", KEY_A, IV_A, g_a, 1793);
        use8 = 1'b1;
        run_and_check("s8_keya", KEY_A, IV_A, g_a, 225);

        // Message schedule vectors.
        for (int i = 0; i < 23; i++) begin
            new_run = (i == 0) || (vecs[i].use8 != vecs[i-1].use8) ||
                      (vecs[i].key != vecs[i-1].key) || (vecs[i].iv != vecs[i-1].iv);
            if (new_run) begin
                use8 = vecs[i].use8;
                reset_dut();
                applyStimulus(vecs[i].key, vecs[i].iv);
            end
            wait_step(vecs[i].step, ok);
            checkOutput($sformatf("mbit_reach_%0d", i), ok, 1);
            checkOutput($sformatf("mbit_vec_%0d_step_%0d", i, vecs[i].step), cur_mbit, vecs[i].exp);
        end

        // Start while busy must be ignored, including its new key/IV.
        use8 = 1'b0;
        reset_dut();
        applyStimulus(KEY_A, IV_A);
        repeat (98) @(negedge clk);
        key_in  = KEY_B;
        iv_in   = IV_B;
        start_1 = 1'b1;
        @(negedge clk);
        start_1 = 1'b0;
        checkOutput("busy_start_busy", cur_busy, 1);
        checkOutput("busy_start_step", cur_step, 99);
        wait_done(cycles, seen);
        checkOutput("busy_start_done_seen", seen, 1);
        checkOutput("busy_start_state", cur_state, g_a);
        checkOutput("busy_start_steps", cur_step, 1792);

        // Reset mid-run aborts without a done pulse; a restart recovers.
        applyStimulus(KEY_B, IV_B);
        wait_step(900, ok);
        checkOutput("abort_reach_900", ok, 1);
        rst_1 = 1'b1;
        #1;
        check_idle("abort_async");
        @(negedge clk);
        rst_1 = 1'b0;
        done_during = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cur_done) done_during = 1'b1;
        end
        checkOutput("abort_no_done", done_during, 0);
        check_idle("abort_after");
        run_and_check("abort_restart", KEY_B, IV_B, g_b, 1793);

        // Back-to-back: start accepted in the done cycle.
        use8 = 1'b1;
        reset_dut();
        applyStimulus(KEY_A, IV_A);
        wait_done(cycles, seen);
        checkOutput("b2b_first_done", seen, 1);
        checkOutput("b2b_first_state", cur_state, g_a);
        applyStimulus(KEY_B, IV_B);
        checkOutput("b2b_valid_drop", cur_valid, 0);
        checkOutput("b2b_busy", cur_busy, 1);
        checkOutput("b2b_ready", cur_ready, 0);
        wait_done(cycles, seen);
        checkOutput("b2b_second_done", seen, 1);
        checkOutput("b2b_second_latency", cycles, 225);
        checkOutput("b2b_second_state", cur_state, g_b);
        checkOutput("b2b_second_valid", cur_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
